// File: rtl/reg_share_arb_pkg.sv
// Shared definitions for the register-sharing arbiter: FSM state encoding
// and the index-width helper used to size requester indices.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Bits needed to index n requesters, never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_share_arb_if.sv
// Requester-side bus of the register-sharing arbiter: request/data in,
// grant/ack/shared-register contents out.
interface reg_share_arb_if #(
  parameter int BIT  = 8,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]     req;
  logic [NREQ*BIT-1:0] din;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     ack;
  logic [BIT-1:0]      out;
  logic                busy;

  modport master (output req, din, input gnt, ack, out, busy);
  modport slave  (input req, din, output gnt, ack, out, busy);
endinterface

// File: rtl/reg_share_arb_rr_pick.sv
// Combinational requester selection. Round-robin search upward from last+1
// by default; REG_ARB_FIXED_PRIO_EN switches to lowest-index-wins.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   idx,
  output logic            valid
);

`ifdef REG_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[IW'(i)]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end
`else
  // Walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    int          c;
    logic [IW-1:0] ci;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    ci    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      c  = (int'(last) + k) % NREQ;
      ci = IW'(c);
      if (req[ci]) begin
        idx   = ci;
        valid = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/reg_share_arb.sv
// Shares one BIT-wide holding register among NREQ requesters with an
// IDLE/GNT/ACK sequence. Optional macro: REG_ARB_FIXED_PRIO_EN (in rr_pick).
module reg_share_arb
  import reg_arb_pkg::*;
#(
  parameter int BIT  = 8,
  parameter int NREQ = 4
) (
  input logic          clk,
  input logic          rst,
  reg_share_arb_if.slave bus
);

  localparam int IW = idx_w(NREQ);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [BIT-1:0]  out_q, out_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic [BIT-1:0]  din_a [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) din_a[i] = bus.din[i*BIT +: BIT];
  end

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (pick_vld) begin
        idx_d   = pick_idx;
        gnt_d   = NREQ'(1) << pick_idx;
        state_d = GNT;
      end
      // A requester that drops req while granted aborts without a write.
      GNT: if (bus.req[idx_q]) begin
        out_d   = din_a[idx_q];
        ack_d   = NREQ'(1) << idx_q;
        last_d  = idx_q;
        state_d = ACK;
      end else begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      ACK: begin
        ack_d   = '0;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        ack_d   = '0;
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      out_q   <= out_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.out  = out_q;
  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_reg_share_arb.sv
// Directed and randomized-invariant bench for reg_share_arb (BIT=8, NREQ=4).
module tb_reg_share_arb;
  localparam int BIT  = 8;
  localparam int NREQ = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_share_arb_if #(.BIT(BIT), .NREQ(NREQ)) bus ();

  reg_share_arb #(.BIT(BIT), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  dv [NREQ];
  int          seq3 [5];
  int          g4, g5a, g5b;
  logic [31:0] pdin;
  logic [7:0]  pout;
  logic [7:0]  exp_out;

  initial begin
    checks = 0;
    errors = 0;
`ifdef REG_ARB_FIXED_PRIO_EN
    seq3 = '{0, 0, 0, 0, 0};
    g4 = 0; g5a = 1; g5b = 1;
`else
    seq3 = '{0, 1, 2, 3, 0};
    g4 = 1; g5a = 3; g5b = 1;
`endif
    dv = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset state
    rst = 1'b1;
    bus.req = '0;
    bus.din = '0;
    tick();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_out", 32'(bus.out), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    tick();

    // Single requester 2
    bus.req = 4'b0100;
    bus.din = 32'h00A5_0000;
    tick();
    chk("t2_gnt", 32'(bus.gnt), 32'h4);
    chk("t2_ack0", 32'(bus.ack), 32'h0);
    chk("t2_busy", 32'(bus.busy), 32'h1);
    tick();
    chk("t2_out", 32'(bus.out), 32'hA5);
    chk("t2_ack", 32'(bus.ack), 32'h4);
    bus.req = '0;
    tick();
    chk("t2_clr_gnt", 32'(bus.gnt), 32'h0);
    chk("t2_clr_ack", 32'(bus.ack), 32'h0);
    chk("t2_clr_busy", 32'(bus.busy), 32'h0);
    chk("t2_hold_out", 32'(bus.out), 32'hA5);

    // Fresh pointer, all requesting, each drops for one cycle after its ack
    rst = 1'b1;
    #2;
    chk("t3_rst_out", 32'(bus.out), 32'h0);
    rst = 1'b0;
    bus.din = {dv[3], dv[2], dv[1], dv[0]};
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t3_gnt", 32'(bus.gnt), 32'h1 << seq3[n]);
      tick();
      chk("t3_ack", 32'(bus.ack), 32'h1 << seq3[n]);
      chk("t3_out", 32'(bus.out), 32'(dv[seq3[n]]));
      bus.req[seq3[n]] = 1'b0;
      tick();
      chk("t3_idle", 32'({bus.gnt, bus.ack}), 32'h0);
      bus.req[seq3[n]] = 1'b1;
    end
    bus.req = '0;
    tick();

    // Abort: requester 1 drops during GNT; pointer must not move
    bus.req = 4'b0010;
    tick();
    chk("t4_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    tick();
    chk("t4_no_ack", 32'(bus.ack), 32'h0);
    chk("t4_gnt_clr", 32'(bus.gnt), 32'h0);
    chk("t4_out_hold", 32'(bus.out), 32'h11);
    chk("t4_busy", 32'(bus.busy), 32'h0);
    bus.req = 4'b1111;
    tick();
    chk("t4_regnt", 32'(bus.gnt), 32'h1 << g4);
    tick();
    chk("t4_ack", 32'(bus.ack), 32'h1 << g4);
    chk("t4_out", 32'(bus.out), 32'(dv[g4]));
    bus.req = '0;
    tick();

    // req=1010 held with last=1; din of requester 0 must never reach out
    bus.req = 4'b1010;
    bus.din[7:0] = 8'hEE;
    tick();
    chk("t5_gnt_a", 32'(bus.gnt), 32'h1 << g5a);
    tick();
    chk("t5_out_a", 32'(bus.out), 32'(dv[g5a]));
    tick();
    tick();
    chk("t5_gnt_b", 32'(bus.gnt), 32'h1 << g5b);
    tick();
    chk("t5_ack_b", 32'(bus.ack), 32'h1 << g5b);
    chk("t5_out_b", 32'(bus.out), 32'(dv[g5b]));
    bus.req = '0;
    tick();

    // Random traffic: invariants and register-update rule
    for (int n = 0; n < 1000; n++) begin
      pdin = bus.din;
      pout = bus.out;
      tick();
      chk("r_gnt_onehot0", 32'($onehot0(bus.gnt)), 32'h1);
      chk("r_ack_in_gnt", 32'(bus.ack & ~bus.gnt), 32'h0);
      chk("r_ack_onehot0", 32'($onehot0(bus.ack)), 32'h1);
      if (bus.ack != '0) begin
        exp_out = pout;
        for (int i = 0; i < NREQ; i++)
          if (bus.ack[i]) exp_out = pdin[i*BIT +: BIT];
        chk("r_out_write", 32'(bus.out), 32'(exp_out));
      end else begin
        chk("r_out_hold", 32'(bus.out), 32'(pout));
      end
      bus.req = NREQ'($urandom_range(0, 15));
      bus.din = $urandom;
    end
    bus.req = '0;
    tick();
    tick();
    tick();

    // Asynchronous reset while in GNT
    bus.req = 4'b0001;
    bus.din = 32'h0000_0077;
    tick();
    chk("t1_gnt", 32'(bus.gnt), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_gnt_clr", 32'(bus.gnt), 32'h0);
    chk("t1_ack_clr", 32'(bus.ack), 32'h0);
    chk("t1_out_clr", 32'(bus.out), 32'h0);
    chk("t1_busy_clr", 32'(bus.busy), 32'h0);
    tick();
    chk("t1_out_held", 32'(bus.out), 32'h0);
    chk("t1_ack_held", 32'(bus.ack), 32'h0);
    bus.req = '0;
    rst = 1'b0;
    tick();
    chk("t1_out_after", 32'(bus.out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
